// File: rtl/disparity_framer.sv
// disparity_framer
// Tags a raw stream of disparity samples from the stereo core with their pixel
// position, replaces disparities in the invalid border (left columns and top
// lines, where the matching window did not fully overlap) with INVALID_CODE,
// and buffers the result in a small first-word-fall-through output FIFO.
//
// Output handshake: a word transfers on a rising clk edge where out_valid and
// out_ready are both high. out_valid never depends on out_ready, and while
// out_valid is high and out_ready is low the word (out_disp/out_sof/out_eol)
// holds stable. The input side has no back-pressure: a sample that arrives
// while the buffer is full is dropped and the sticky overflow flag is raised.

module disparity_framer #(
   parameter int LINE_LENGTH  = 640,
   parameter int NUM_LINES    = 480,
   parameter int DISP_WIDTH   = 6,
   parameter int MASK_COLS    = 59,
   parameter int MASK_ROWS    = 19,
   parameter int INVALID_CODE = 63,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic                  in_sof,
   input  logic [DISP_WIDTH-1:0] in_disp,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DISP_WIDTH-1:0] out_disp,
   output logic                  out_sof,
   output logic                  out_eol,
   output logic [15:0]           frame_count,
   output logic                  overflow
);

   localparam int COL_W = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
   localparam int ROW_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CW    = AW + 1;

   localparam logic [COL_W-1:0]      LAST_COL = COL_W'(LINE_LENGTH - 1);
   localparam logic [ROW_W-1:0]      LAST_ROW = ROW_W'(NUM_LINES - 1);
   localparam logic [DISP_WIDTH-1:0] INV_DISP = DISP_WIDTH'(INVALID_CODE);
   localparam logic [CW-1:0]         FULL_CNT = CW'(FIFO_DEPTH);

   // position counters: position of the next sample that arrives
   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic [15:0]      r_frame_count;

   // tagging stage register
   logic                  r_stg_valid;
   logic [DISP_WIDTH-1:0] r_stg_disp;
   logic                  r_stg_sof;
   logic                  r_stg_eol;

   // output FIFO storage and bookkeeping
   logic [DISP_WIDTH-1:0] r_mem_disp [FIFO_DEPTH];
   logic                  r_mem_sof  [FIFO_DEPTH];
   logic                  r_mem_eol  [FIFO_DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic                  r_overflow;

   // position of the current sample; in_sof forces it to (0,0)
   logic [COL_W-1:0]      w_cur_col;
   logic [ROW_W-1:0]      w_cur_row;
   logic                  w_at_last_col;
   logic                  w_at_last_row;
   logic                  w_masked;
   logic [DISP_WIDTH-1:0] w_tag_disp;
   logic                  w_tag_sof;
   logic                  w_tag_eol;

   logic w_out_valid;
   logic w_full;
   logic w_pop;
   logic w_push_ok;
   logic w_drop;

   // resolve the current pixel position and build its tag
   always_comb begin
      w_cur_col     = in_sof ? '0 : r_col;
      w_cur_row     = in_sof ? '0 : r_row;
      w_at_last_col = (w_cur_col == LAST_COL);
      w_at_last_row = (w_cur_row == LAST_ROW);
      w_masked      = (32'(w_cur_col) < 32'(MASK_COLS)) ||
                      (32'(w_cur_row) < 32'(MASK_ROWS));
      w_tag_disp    = w_masked ? INV_DISP : in_disp;
      w_tag_sof     = (w_cur_col == '0) && (w_cur_row == '0);
      w_tag_eol     = w_at_last_col;
   end

   // advance the raster position on every sample, dropped or not, and count
   // frames whose last pixel has been seen
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_col         <= '0;
         r_row         <= '0;
         r_frame_count <= '0;
      end else if (in_valid) begin
         if (w_at_last_col) begin
            r_col <= '0;
            r_row <= w_at_last_row ? '0 : (w_cur_row + ROW_W'(1));
         end else begin
            r_col <= w_cur_col + COL_W'(1);
            r_row <= w_cur_row;
         end
         if (w_at_last_col && w_at_last_row) begin
            r_frame_count <= r_frame_count + 16'd1;
         end
      end
   end

   // one register stage between tagging and the FIFO write port
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stg_valid <= 1'b0;
         r_stg_disp  <= '0;
         r_stg_sof   <= 1'b0;
         r_stg_eol   <= 1'b0;
      end else begin
         r_stg_valid <= in_valid;
         if (in_valid) begin
            r_stg_disp <= w_tag_disp;
            r_stg_sof  <= w_tag_sof;
            r_stg_eol  <= w_tag_eol;
         end
      end
   end

   // FIFO control: a pop in the same cycle frees the slot a full push needs
   always_comb begin
      w_out_valid = (r_count != '0);
      w_full      = (r_count == FULL_CNT);
      w_pop       = w_out_valid && out_ready;
      w_push_ok   = r_stg_valid && (!w_full || w_pop);
      w_drop      = r_stg_valid && w_full && !w_pop;
   end

   // FIFO storage writes; cleared on reset so the head reads zero while empty
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem_disp[i] <= '0;
            r_mem_sof[i]  <= 1'b0;
            r_mem_eol[i]  <= 1'b0;
         end
      end else if (w_push_ok) begin
         r_mem_disp[r_wr_ptr] <= r_stg_disp;
         r_mem_sof[r_wr_ptr]  <= r_stg_sof;
         r_mem_eol[r_wr_ptr]  <= r_stg_eol;
      end
   end

   // FIFO pointers, occupancy and the sticky drop flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // head of the FIFO is presented directly (first-word fall-through)
   always_comb begin
      out_valid   = w_out_valid;
      out_disp    = r_mem_disp[r_rd_ptr];
      out_sof     = r_mem_sof[r_rd_ptr];
      out_eol     = r_mem_eol[r_rd_ptr];
      frame_count = r_frame_count;
      overflow    = r_overflow;
   end

endmodule

// File: tb/tb_disparity_framer.sv
// Testbench for disparity_framer, run with a small frame geometry so whole
// frames fit in a short simulation. The reference model tracks the raster
// position as a single pixel index and keeps the output buffer as a queue.

module tb_disparity_framer;

   localparam int LL = 16;
   localparam int NL = 8;
   localparam int DW = 6;
   localparam int MC = 5;
   localparam int MR = 3;
   localparam int IC = 63;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_sof;
   logic [DW-1:0] in_disp;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_disp;
   logic          out_sof;
   logic          out_eol;
   logic [15:0]   frame_count;
   logic          overflow;

   always #5 clk = ~clk;

   disparity_framer #(
      .LINE_LENGTH(LL), .NUM_LINES(NL), .DISP_WIDTH(DW), .MASK_COLS(MC),
      .MASK_ROWS(MR), .INVALID_CODE(IC), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
      .in_disp(in_disp), .out_valid(out_valid), .out_ready(out_ready),
      .out_disp(out_disp), .out_sof(out_sof), .out_eol(out_eol),
      .frame_count(frame_count), .overflow(overflow)
   );

   typedef struct packed {
      logic [DW-1:0] disp;
      logic          sof;
      logic          eol;
   } word_t;

   // reference model state
   word_t m_fifo[$];
   word_t m_stage;
   bit    m_stage_v;
   int    m_pos;
   int    m_frames;
   bit    m_ovf;

   int checks   = 0;
   int failures = 0;

   task automatic model_clear();
      m_fifo.delete();
      m_stage_v = 1'b0;
      m_stage   = '0;
      m_pos     = 0;
      m_frames  = 0;
      m_ovf     = 1'b0;
   endtask

   // one rising edge of the model, from the inputs that were applied
   task automatic model_edge(input logic v, input logic s, input logic [DW-1:0] d, input logic r);
      bit    pop;
      bit    was_full;
      int    pos;
      int    col;
      int    row;
      word_t w;
      was_full = (m_fifo.size() == FD);
      pop      = (m_fifo.size() != 0) && r;
      if (pop) void'(m_fifo.pop_front());
      if (m_stage_v) begin
         if (was_full && !pop) m_ovf = 1'b1;
         else m_fifo.push_back(m_stage);
      end
      m_stage_v = v;
      if (v) begin
         pos    = s ? 0 : m_pos;
         col    = pos % LL;
         row    = pos / LL;
         w.disp = (col < MC || row < MR) ? DW'(IC) : d;
         w.sof  = (pos == 0);
         w.eol  = (col == LL - 1);
         m_stage = w;
         if (pos == LL * NL - 1) m_frames = (m_frames + 1) % 65536;
         m_pos = (pos + 1) % (LL * NL);
      end
   endtask

   // driver: entered and left at a falling edge
   task automatic drive(input logic v, input logic s, input logic [DW-1:0] d, input logic r);
      in_valid  = v;
      in_sof    = s;
      in_disp   = d;
      out_ready = r;
      @(posedge clk);
      model_edge(v, s, d, r);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      in_disp   = '0;
      out_ready = 1'b0;
      model_clear();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      model_clear();
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      checks++; if (out_disp !== '0) begin failures++; $display("FAIL reset_out_disp got=%0d want=0", out_disp); end
      checks++; if (out_sof !== 1'b0) begin failures++; $display("FAIL reset_out_sof got=%b want=0", out_sof); end
      checks++; if (out_eol !== 1'b0) begin failures++; $display("FAIL reset_out_eol got=%b want=0", out_eol); end
      checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL reset_frame_count got=%0d want=0", frame_count); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b want=0", overflow); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_full_frame();
      int n_out = 0;
      int n_sof = 0;
      int n_eol = 0;
      int n_inv = 0;
      do_reset();
      for (int i = 0; i < LL * NL + 4; i++) begin
         checks++;
         if (out_valid !== (m_fifo.size() != 0)) begin
            failures++; $display("FAIL frame_out_valid i=%0d got=%b want=%b", i, out_valid, m_fifo.size() != 0);
         end
         if (out_valid === 1'b1 && m_fifo.size() != 0) begin
            checks++;
            if ({out_disp, out_sof, out_eol} !== m_fifo[0]) begin
               failures++; $display("FAIL frame_word i=%0d got=%h want=%h", i, {out_disp, out_sof, out_eol}, m_fifo[0]);
            end
            n_out++;
            if (out_sof) n_sof++;
            if (out_eol) n_eol++;
            if (out_disp == DW'(IC)) n_inv++;
         end
         drive(i < LL * NL, i == 0, 6'd12, 1'b1);
      end
      checks++; if (n_out != LL * NL) begin failures++; $display("FAIL frame_count_out got=%0d want=%0d", n_out, LL * NL); end
      checks++; if (n_sof != 1) begin failures++; $display("FAIL frame_count_sof got=%0d want=1", n_sof); end
      checks++; if (n_eol != NL) begin failures++; $display("FAIL frame_count_eol got=%0d want=%0d", n_eol, NL); end
      checks++; if (n_inv != LL * NL - (LL - MC) * (NL - MR)) begin
         failures++; $display("FAIL frame_count_invalid got=%0d want=%0d", n_inv, LL * NL - (LL - MC) * (NL - MR));
      end
      checks++; if (frame_count !== 16'd1) begin failures++; $display("FAIL frame_frame_count got=%0d want=1", frame_count); end
   endtask

   // runs right after a full frame so frame_count and overflow are nonzero
   task automatic test_reset_mid();
      for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, DW'($urandom_range(0, 62)), 1'b0);
      drive(1'b0, 1'b0, '0, 1'b0);
      drive(1'b0, 1'b0, '0, 1'b1);
      drive(1'b0, 1'b0, '0, 1'b0);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre_valid got=%b want=1", out_valid); end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL midrst_pre_overflow got=%b want=1", overflow); end
      rst = 1'b0;
      model_clear();
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
      checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL midrst_frame_count got=%0d want=0", frame_count); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL midrst_overflow got=%b want=0", overflow); end
      @(negedge clk);
      rst = 1'b1;
      drive(1'b1, 1'b0, 6'd7, 1'b0);
      drive(1'b0, 1'b0, '0, 1'b0);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL midrst_first_valid got=%b want=1", out_valid); end
      checks++; if ({out_disp, out_sof, out_eol} !== {DW'(IC), 1'b1, 1'b0}) begin
         failures++; $display("FAIL midrst_first_word got=%h want=%h", {out_disp, out_sof, out_eol}, {DW'(IC), 1'b1, 1'b0});
      end
      drive(1'b0, 1'b0, '0, 1'b1);
   endtask

   task automatic test_latency();
      do_reset();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_idle got=%b want=0", out_valid); end
      drive(1'b1, 1'b1, 6'd9, 1'b0);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_cycle1 got=%b want=0", out_valid); end
      drive(1'b0, 1'b0, '0, 1'b0);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL lat_cycle2 got=%b want=1", out_valid); end
      checks++; if ({out_disp, out_sof} !== {DW'(IC), 1'b1}) begin
         failures++; $display("FAIL lat_word got=%h want=%h", {out_disp, out_sof}, {DW'(IC), 1'b1});
      end
      drive(1'b0, 1'b0, '0, 1'b1);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_drained got=%b want=0", out_valid); end
   endtask

   task automatic test_overflow();
      logic [DW-1:0] d[7];
      do_reset();
      for (int i = 0; i < 57; i++) drive(1'b1, i == 0, DW'($urandom_range(0, 62)), 1'b1);
      repeat (3) drive(1'b0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 7; i++) d[i] = DW'($urandom_range(0, 62));
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b0, d[i], 1'b0);
         if (i == 4) begin
            checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_at_full got=%b want=0", overflow); end
         end
         if (i == 5) begin
            checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_after_drop got=%b want=1", overflow); end
         end
      end
      drive(1'b0, 1'b0, '0, 1'b0);
      checks++; if ({out_disp, out_sof, out_eol} !== {d[0], 1'b0, 1'b0}) begin
         failures++; $display("FAIL ovf_hold got=%h want=%h", {out_disp, out_sof, out_eol}, {d[0], 1'b0, 1'b0});
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (out_valid !== 1'b1 || {out_disp, out_sof, out_eol} !== {d[k], 1'b0, 1'b0}) begin
            failures++; $display("FAIL ovf_word k=%0d got=%b/%h want=1/%h", k, out_valid, {out_disp, out_sof, out_eol}, {d[k], 1'b0, 1'b0});
         end
         drive(1'b0, 1'b0, '0, 1'b1);
      end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%b want=0", out_valid); end
      drive(1'b1, 1'b0, d[6], 1'b1);
      drive(1'b0, 1'b0, '0, 1'b0);
      checks++; if ({out_valid, out_disp, out_sof, out_eol} !== {1'b1, d[6], 1'b0, 1'b1}) begin
         failures++; $display("FAIL ovf_aligned got=%h want=%h", {out_valid, out_disp, out_sof, out_eol}, {1'b1, d[6], 1'b0, 1'b1});
      end
      drive(1'b0, 1'b0, '0, 1'b1);
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 5; i++) drive(1'b1, i == 0, DW'($urandom_range(0, 63)), 1'b0);
      for (int i = 0; i < 28; i++) begin
         checks++;
         if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_overflow i=%0d got=%b want=0", i, overflow); end
         checks++;
         if (out_valid !== (m_fifo.size() != 0)) begin
            failures++; $display("FAIL b2b_valid i=%0d got=%b want=%b", i, out_valid, m_fifo.size() != 0);
         end else if (out_valid === 1'b1) begin
            checks++;
            if ({out_disp, out_sof, out_eol} !== m_fifo[0]) begin
               failures++; $display("FAIL b2b_word i=%0d got=%h want=%h", i, {out_disp, out_sof, out_eol}, m_fifo[0]);
            end
         end
         drive(i < 20, 1'b0, DW'($urandom_range(0, 63)), 1'b1);
      end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b want=0", out_valid); end
   endtask

   task automatic test_resync();
      do_reset();
      for (int i = 0; i < 87; i++) drive(1'b1, i == 0, DW'($urandom_range(0, 62)), 1'b1);
      repeat (3) drive(1'b0, 1'b0, '0, 1'b1);
      drive(1'b1, 1'b1, 6'd20, 1'b1);
      drive(1'b0, 1'b0, '0, 1'b0);
      checks++; if ({out_valid, out_disp, out_sof, out_eol} !== {1'b1, DW'(IC), 1'b1, 1'b0}) begin
         failures++; $display("FAIL resync_word got=%h want=%h", {out_valid, out_disp, out_sof, out_eol}, {1'b1, DW'(IC), 1'b1, 1'b0});
      end
      checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL resync_frame_count got=%0d want=0", frame_count); end
      for (int i = 1; i < LL * NL; i++) drive(1'b1, 1'b0, 6'd21, 1'b1);
      repeat (3) drive(1'b0, 1'b0, '0, 1'b1);
      checks++; if (frame_count !== 16'd1) begin failures++; $display("FAIL resync_frame_done got=%0d want=1", frame_count); end
   endtask

   task automatic test_random();
      logic v;
      logic s;
      logic r;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         checks++;
         if (out_valid !== (m_fifo.size() != 0)) begin
            failures++; $display("FAIL rand_valid i=%0d got=%b want=%b", i, out_valid, m_fifo.size() != 0);
         end else if (out_valid === 1'b1) begin
            checks++;
            if ({out_disp, out_sof, out_eol} !== m_fifo[0]) begin
               failures++; $display("FAIL rand_word i=%0d got=%h want=%h", i, {out_disp, out_sof, out_eol}, m_fifo[0]);
            end
         end
         checks++;
         if (overflow !== m_ovf) begin failures++; $display("FAIL rand_overflow i=%0d got=%b want=%b", i, overflow, m_ovf); end
         checks++;
         if (frame_count !== 16'(m_frames)) begin
            failures++; $display("FAIL rand_frame_count i=%0d got=%0d want=%0d", i, frame_count, m_frames);
         end
         v = ($urandom_range(0, 3) != 0) && (i < 590);
         s = ($urandom_range(0, 299) == 0);
         r = ($urandom_range(0, 3) != 0) || (i >= 590);
         drive(v, s, DW'($urandom_range(0, 63)), r);
      end
   endtask

   initial begin
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      in_disp   = '0;
      out_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_full_frame();
      test_reset_mid();
      test_latency();
      test_overflow();
      test_back_to_back();
      test_resync();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/disparity_framer.md
DISPARITY_FRAMER -- requirements
Module: disparity_framer

Interface
REQ-001: Parameter LINE_LENGTH, default 640, pixels per line.
REQ-002: Parameter NUM_LINES, default 480, lines per frame.
REQ-003: Parameter DISP_WIDTH, default 6, disparity width in bits.
REQ-004: Parameter MASK_COLS, default 59, leading columns of each line whose disparity is invalid (window width 20 + max disparity 40 - 1).
REQ-005: Parameter MASK_ROWS, default 19, leading lines of each frame whose disparity is invalid (window height - 1).
REQ-006: Parameter INVALID_CODE, default 63, disparity value substituted for masked pixels.
REQ-007: Parameter FIFO_DEPTH, default 4, output buffer entries, power of two, at least 2.
REQ-008: Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-009: Port rst, input, 1, asynchronous active-low reset.
REQ-010: Port in_valid, input, 1, in_disp carries a disparity sample this cycle.
REQ-011: Port in_sof, input, 1, sample is pixel (0,0) of a new frame; sampled only with in_valid.
REQ-012: Port in_disp, input, DISP_WIDTH, argmin disparity from the stereo core.
REQ-013: Port out_valid, output, 1, output word available.
REQ-014: Port out_ready, input, 1, consumer accepts the word when out_valid is also high.
REQ-015: Port out_disp, output, DISP_WIDTH, masked disparity.
REQ-016: Port out_sof, output, 1, word is pixel (0,0).
REQ-017: Port out_eol, output, 1, word is the last pixel of a line.
REQ-018: Port frame_count, output, 16, completed-frame counter.
REQ-019: Port overflow, output, 1, sticky flag: a sample was dropped.

Function
REQ-020: Column counter col SHALL advance by 1 on each in_valid, wrapping from LINE_LENGTH-1 to 0; row counter row SHALL advance on that wrap, wrapping from NUM_LINES-1 to 0.
REQ-021: in_valid with in_sof SHALL tag the sample as (0,0); the next sample is (1,0); this overrides counter state mid-frame.
REQ-022: Tagged sample SHALL carry disp = INVALID_CODE if col < MASK_COLS or row < MASK_ROWS, else in_disp unmodified.
REQ-023: Tag sof SHALL be (col==0 && row==0); tag eol SHALL be (col==LINE_LENGTH-1).
REQ-024: frame_count SHALL increment, mod 2^16, when the sample at (LINE_LENGTH-1, NUM_LINES-1) is accepted by the counters; it SHALL NOT increment on an in_sof resync.
REQ-025: Tagged samples SHALL pass through one register stage, then be pushed into a FIFO_DEPTH first-word-fall-through FIFO; latency in_valid to out_valid with FIFO empty SHALL be exactly 2 cycles.
REQ-026: The FIFO SHALL pop when out_valid && out_ready; out_disp/out_sof/out_eol SHALL be the head entry and SHALL hold stable while out_valid && !out_ready.
REQ-027: Push when full and not popping in the same cycle SHALL drop the sample and set overflow; push when full with a same-cycle pop SHALL succeed.
REQ-028: Counters SHALL advance on every in_valid regardless of drops, preserving pixel alignment.
REQ-029: overflow SHALL clear only on reset.
REQ-030: With the FIFO empty, out_valid SHALL be 0 and out_disp/out_sof/out_eol SHALL be don't-care.

Reset
REQ-031: While rst is low: col=0, row=0, FIFO empty, stage register invalid, out_valid=0, out_disp=0, out_sof=0, out_eol=0, frame_count=0, overflow=0.
REQ-032: Reset asserted mid-frame SHALL discard all buffered samples; the first in_valid after release SHALL be tagged (0,0) with in_sof either 0 or 1.

Verification
REQ-033: Defaults; reset; in_sof then 640x480 samples, in_disp=12, out_ready=1 -> 307200 outputs; out_disp=63 for row<19 or col<59, else 12; one out_sof; 480 out_eol; frame_count=1.
REQ-034: Single sample at idle -> out_valid rises exactly 2 cycles after in_valid, out_sof=1, out_disp=63.
REQ-035: out_ready=0, 6 consecutive samples -> 4 buffered, overflow=1 from the 5th push; out_ready=1 -> 4 words in order, counters aligned (7th sample tagged col=6).
REQ-036: FIFO full, in_valid and out_ready both high for 20 cycles -> no drop, overflow stays 0.
REQ-037: in_sof pulsed at col=300,row=100 -> that word out_sof=1, out_disp=63, frame_count unchanged.
REQ-038: rst low for 1 cycle with 3 words buffered -> out_valid=0 immediately, frame_count=0, overflow=0; next sample tagged (0,0).
